// File: rtl/pickups_pkg.sv
// Shared constants for the pickup subsystem: slot geometry and scheduler state encoding.
// The renderer reads the same slot coordinates, so they live here rather than in either block.
package pickups_pkg;

  localparam int N_PICKUPS   = 5;
  localparam int PICKUP_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    SCAN       = 3'd2,
    DONE       = 3'd3,
    CLEARED    = 3'd4
  } sched_state_e;

  function automatic logic [11:0] slot_x(input int unsigned i);
    case (i)
      0:       slot_x = 12'd100;
      1:       slot_x = 12'd300;
      2:       slot_x = 12'd500;
      3:       slot_x = 12'd200;
      4:       slot_x = 12'd600;
      default: slot_x = 12'd0;
    endcase
  endfunction

  function automatic logic [11:0] slot_y(input int unsigned i);
    case (i)
      0, 1, 2: slot_y = 12'd100;
      3, 4:    slot_y = 12'd400;
      default: slot_y = 12'd0;
    endcase
  endfunction

endpackage

// File: rtl/pickup_overlap.sv
// Combinational axis-aligned box overlap test between box A and box B.
// Compares in 13 bits so position + size never wraps.
module pickup_overlap #(
  parameter int A_SIZE = 32,
  parameter int B_SIZE = 16
) (
  input  logic [11:0] ax_i,
  input  logic [11:0] ay_i,
  input  logic [11:0] bx_i,
  input  logic [11:0] by_i,
  output logic        hit_o
);

  localparam logic [12:0] AS = 13'(A_SIZE);
  localparam logic [12:0] BS = 13'(B_SIZE);

  logic [12:0] ax, ay, bx, by;
  assign ax = {1'b0, ax_i};
  assign ay = {1'b0, ay_i};
  assign bx = {1'b0, bx_i};
  assign by = {1'b0, by_i};

  assign hit_o = (ax < bx + BS) && (bx < ax + AS) &&
                 (ay < by + BS) && (by < ay + AS);

endmodule

// File: rtl/pickups_scheduler.sv
// Frame-synchronous pickup controller: owns the active mask, scans one slot per cycle
// after each vblank rising edge, and tracks score and completed levels.
module pickups_scheduler #(
  parameter int N_PICKUPS   = pickups_pkg::N_PICKUPS,
  parameter int HERO_SIZE   = 32,
  parameter int PICKUP_SIZE = pickups_pkg::PICKUP_SIZE,
  parameter int LEVEL_DELAY = 120,
  parameter int SCORE_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vblnk_in,
  input  logic                 game_start,
  input  logic [11:0]          hero_x_pos,
  input  logic [11:0]          hero_y_pos,
  output logic [N_PICKUPS-1:0] pickup_active,
  output logic                 collect_pulse,
  output logic                 level_done,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           level
);
  import pickups_pkg::*;

  localparam int IW = (N_PICKUPS > 1) ? $clog2(N_PICKUPS) : 1;
  localparam int DW = (LEVEL_DELAY > 1) ? $clog2(LEVEL_DELAY) : 1;

  sched_state_e         state_q;
  logic                 vblnk_q;
  logic [IW-1:0]        idx_q;
  logic [11:0]          hx_q, hy_q;
  logic [N_PICKUPS-1:0] active_q;
  logic [SCORE_W-1:0]   score_q;
  logic [3:0]           level_q;
  logic [DW-1:0]        delay_q;
  logic                 collect_q, done_q;
  logic                 tick, overlap, hit;

  assign tick = vblnk_in & ~vblnk_q;

  pickup_overlap #(.A_SIZE(HERO_SIZE), .B_SIZE(PICKUP_SIZE)) u_overlap (
    .ax_i (hx_q),
    .ay_i (hy_q),
    .bx_i (slot_x(32'(idx_q))),
    .by_i (slot_y(32'(idx_q))),
    .hit_o(overlap)
  );

  assign hit = overlap & active_q[idx_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      vblnk_q   <= 1'b0;
      idx_q     <= '0;
      hx_q      <= '0;
      hy_q      <= '0;
      active_q  <= '0;
      score_q   <= '0;
      level_q   <= '0;
      delay_q   <= '0;
      collect_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      vblnk_q   <= vblnk_in;
      collect_q <= 1'b0;
      done_q    <= 1'b0;
      if (game_start) begin
        active_q <= '1;
        score_q  <= '0;
        level_q  <= '0;
        delay_q  <= '0;
        state_q  <= WAIT_FRAME;
      end else begin
        case (state_q)
          WAIT_FRAME: if (tick) begin
            hx_q    <= hero_x_pos;
            hy_q    <= hero_y_pos;
            idx_q   <= '0;
            state_q <= SCAN;
          end
          SCAN: begin
            if (hit) begin
              active_q[idx_q] <= 1'b0;
              collect_q       <= 1'b1;
              if (score_q != '1) score_q <= score_q + 1'b1;
            end
            if (idx_q == IW'(N_PICKUPS - 1)) state_q <= DONE;
            else                              idx_q   <= idx_q + 1'b1;
          end
          DONE: begin
            if (active_q == '0) begin
              done_q  <= 1'b1;
              level_q <= level_q + 4'd1;
              delay_q <= '0;
              state_q <= CLEARED;
            end else begin
              state_q <= WAIT_FRAME;
            end
          end
          CLEARED: if (tick) begin
            // The LEVEL_DELAY-th tick after the clear re-arms every slot.
            if (delay_q == DW'(LEVEL_DELAY - 1)) begin
              active_q <= '1;
              state_q  <= WAIT_FRAME;
            end else begin
              delay_q <= delay_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pickup_active = active_q;
  assign collect_pulse = collect_q;
  assign level_done    = done_q;
  assign score         = score_q;
  assign level         = level_q;

endmodule

// File: doc/pickups_scheduler.md
# pickups_scheduler

Frame-synchronous controller sequencing the pickup resource of the game screen. It owns the per-slot active mask consumed by `pickups_management_unit`, detects hero/pickup overlap once per frame during vertical blanking, and maintains score and level progression. It sits between the hero control logic (positions) and the pickup renderer (enable mask), clocked on the pixel clock alongside `vga_timing`.

## Interface
- `N_PICKUPS`, 5: number of pickup slots; slot positions are fixed in the package.
- `HERO_SIZE`, 32: hero bounding-box side, pixels.
- `PICKUP_SIZE`, 16: pickup bounding-box side, pixels.
- `LEVEL_DELAY`, 120: frames between level clear and re-arm.
- `SCORE_W`, 8: score width.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `vblnk_in` in 1: vertical blank from `vga_timing`.
- `game_start` in 1: single-cycle start/restart pulse.
- `hero_x_pos` in 12: hero top-left x.
- `hero_y_pos` in 12: hero top-left y.
- `pickup_active` out N_PICKUPS: slot visible/collectable mask to the renderer.
- `collect_pulse` out 1: one cycle per collected slot.
- `level_done` out 1: one-cycle pulse when the last slot is collected.
- `score` out SCORE_W: collected-pickup count.
- `level` out 4: completed-level count.

## Operation
- States: IDLE, WAIT_FRAME, SCAN, DONE, CLEARED.
- Frame tick: `vblnk_in` registered once; tick = current high AND previous low.
- IDLE (after reset): all outputs zero. Ticks are ignored.
- `game_start` in any state sets `pickup_active` to all ones, `score` to 0, `level` to 0 and the delay counter to 0, then goes to WAIT_FRAME. It has priority over every other event in the same cycle.
- WAIT_FRAME: on tick, latch `hero_x_pos` and `hero_y_pos`, clear the slot index, go to SCAN.
- SCAN: evaluate one slot per cycle, index 0..N_PICKUPS-1.
  - Hit when the slot is active and the boxes overlap. Compare in 13-bit unsigned: hx < px+PICKUP_SIZE && px < hx+HERO_SIZE, with the same rule on y. No wrap.
  - On a hit: clear the slot bit, pulse `collect_pulse`, increment `score`. `score` saturates at 2^SCORE_W-1.
  - After the last slot, go to DONE.
- DONE, one cycle:
  - If `pickup_active` is 0: pulse `level_done`, increment `level` (wraps at 15), clear the delay counter, go to CLEARED.
  - Otherwise go to WAIT_FRAME.
- CLEARED: count ticks. On reaching LEVEL_DELAY, set `pickup_active` to all ones and go to WAIT_FRAME.
- A tick arriving during SCAN or DONE is ignored. Frames are assumed far longer than N_PICKUPS+2 cycles.
- Hero positions change mid-scan without effect; the latched values are used.
- An asynchronous reset mid-operation returns to IDLE and clears all outputs immediately.

## Timing
- Tick detected in cycle T: positions latched at T, WAIT_FRAME→SCAN at the T edge.
- Slot i is evaluated in cycle T+1+i. Its `pickup_active` bit, `score` and `collect_pulse` are visible in cycle T+2+i.
- DONE runs in cycle T+1+N_PICKUPS. `level_done` and the `level` increment are visible in T+2+N_PICKUPS.
- Re-arm happens on the LEVEL_DELAY-th tick after the clear. The new mask is visible in the next cycle.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package/header `pickups_pkg` holds:
  - N_PICKUPS
  - slot coordinate constants: slot0 (100,100), slot1 (300,100), slot2 (500,100), slot3 (200,400), slot4 (600,400)
  - PICKUP_SIZE
  - the state encoding
- `pickups_management_unit` reads the same coordinates from the package.
- Sub-module `pickup_overlap`: purely combinational box-overlap comparator (12-bit positions plus sizes → hit), reused by future enemy collision.

## Test plan
- Reset, then ticks without `game_start` → all outputs stay 0; state remains IDLE.
- `game_start`, hero at (0,0), 3 ticks → `pickup_active`=5'b11111, `score`=0, no pulses.
- Hero at (90,95), tick at T → bit0 clears at T+2, `collect_pulse` high for exactly cycle T+2, `score`=1; the next frame gives no further increment.
- Hero at (100,100) then moved mid-scan to (300,100) → only slot0 is collected that frame; slot1 is collected the following frame.
- Collect all 5 slots over successive frames → `level_done` pulses once at T+7 of the final frame, `level`=1. `pickup_active` stays 0 for 119 ticks and returns to 5'b11111 after tick 120.
- `rst` asserted during SCAN → outputs 0 immediately. `score` preset to 255, then a further collection → `score` stays 255. `game_start` coincident with a tick → start wins; no scan that frame.
